maze_wall_lookup: RTL and testbench
===================================

MAZE_WALL_LOOKUP -- requirements
Module: maze_wall_lookup

Interface
REQ-001 CLK  in  1  system clock, 50 MHz, shared with Avalon and VGA timing.
REQ-002 RESET  in  1  synchronous, active-high reset.
REQ-003 AVL_CS, AVL_WRITE, AVL_READ  in  1 each  Avalon-MM slave select/write/read strobes.
REQ-004 AVL_BYTE_EN  in  4  byte enables; bit n covers WRITEDATA[8n+7:8n].
REQ-005 AVL_ADDR  in  10  word address; 0-599 maze words, 600 control/status, 601-1023 unused.
REQ-006 AVL_WRITEDATA  in  32; AVL_READDATA  out  32  Avalon data buses.
REQ-007 DrawX, DrawY  in  10 each  current pixel coordinates from the VGA controller.
REQ-008 maze_wall  out  1  the pixel's maze cell is a wall.
REQ-009 wall_up, wall_down, wall_left, wall_right  out  1 each  wall state of the four neighbouring cells.
REQ-010 maze_ready  out  1  maze committed by software; feeds the game state machine.
REQ-011 clearing  out  1  hardware clear sequence in progress.

Function
REQ-012 Geometry: 160x120 cells of 4x4 pixels; cell cx = DrawX[9:2], cy = DrawY[9:2]; idx = cx + 160*cy (15 bits); word = idx[14:5]; bit = 31 - idx[4:0], so the MSB is the leftmost cell; 5 words per cell row.
REQ-013 Maze write: AVL_CS && AVL_WRITE && AVL_ADDR<600 updates only the enabled bytes of that word at the next CLK edge.
REQ-014 Any accepted maze-word write clears maze_ready at the same edge.
REQ-015 Control write (AVL_ADDR==600): bit1=1 starts a clear; bit0=1 with bit1=0 sets maze_ready; bit1 takes priority; AVL_BYTE_EN[0] must be set for the write to have effect.
REQ-016 Writes to addresses 601-1023 are ignored.
REQ-017 Read: AVL_CS && AVL_READ returns data on AVL_READDATA one cycle later.
REQ-018 Read data: addresses 0-599 return the word; 600 returns {30'b0, clearing, maze_ready}; 601-1023 return 0.
REQ-019 AVL_READDATA holds its last value when no read is issued.
REQ-020 Clear sequencer has two states, IDLE and CLEAR, with a 10-bit counter.
REQ-021 Entering CLEAR sets counter=0, clearing=1 and maze_ready=0.
REQ-022 In CLEAR, the word at address counter is zeroed each cycle; the sequencer returns to IDLE after word 599, so a clear takes exactly 600 cycles.
REQ-023 During CLEAR, maze-word writes and maze_ready-set requests are dropped.
REQ-024 A new clear request during CLEAR restarts the counter at 0.
REQ-025 Lookup pipeline: DrawX/DrawY sampled at edge N; all five lookup outputs are registered and valid after edge N+2, with a fixed 2-cycle latency.
REQ-026 Boundary neighbours read as wall (1):
  - wall_left when cx==0
  - wall_right when cx==159
  - wall_up when cy==0
  - wall_down when cy==119
REQ-027 Off-screen pixels (DrawX>=640 or DrawY>=480) drive all five lookup outputs to 0.
REQ-028 While clearing==1, all five lookup outputs are forced to 0.
REQ-029 Same-cycle write and lookup of one word: the lookup returns the pre-write data (read-before-write); the new data is visible from the next sample.
REQ-030 Left/right neighbours crossing a word boundary (bit 0 / bit 31) take the correct bit of the adjacent word.

Reset
REQ-031 RESET enters CLEAR with counter=0; on the first cycle after RESET deasserts, clearing=1 and maze_ready=0.
REQ-032 RESET sets AVL_READDATA and all lookup output registers to 0.
REQ-033 RESET asserted mid-clear restarts the clear at word 0.
REQ-034 RESET asserted mid-lookup flushes the pipeline, so outputs read 0 until two valid samples have completed.

Verification
REQ-035 Reset, then poll addr 600 -> reads 0x2 for 600 cycles, then 0x0; reading addr 5 -> 0x00000000.
REQ-036 After the clear, write addr 0 = 0x80000000 (BYTE_EN=0xF), write addr 600 = 0x1, drive DrawX=0, DrawY=0 -> 2 cycles later maze_wall=1, wall_left=1, wall_up=1, wall_right=0, wall_down=0; addr 600 reads 0x1.
REQ-037 Write addr 0 = 0x00000001 and addr 1 = 0x80000000, drive DrawX=124 (cx=31) -> maze_wall=1, wall_right=1; then drive DrawX=128 -> maze_wall=1, wall_left=1.
REQ-038 Write addr 3 = 0xFFFFFFFF with BYTE_EN=0x2 -> read addr 3 = 0x0000FF00; maze_ready drops to 0 in the same cycle.
REQ-039 Write 0x2 to addr 600 at cycle 300 of a clear -> clearing stays 1 for a further 600 cycles; a maze write during that window is absent on readback.
REQ-040 Drive DrawX=700, DrawY=10 with a full-wall maze -> all lookup outputs 0; drive DrawX=636, DrawY=476 (cx=159, cy=119) -> wall_right=1, wall_down=1.

Source files
------------

// File: rtl/maze_wall_lookup_if.sv
// Avalon-MM slave bus for the maze wall bitmap: word-addressed, 32-bit data,
// per-byte write enables, read data returned one cycle after the read strobe.
interface maze_wall_lookup_if;
  logic        cs;
  logic        write;
  logic        read;
  logic [3:0]  byte_en;
  logic [9:0]  addr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output cs, write, read, byte_en, addr, writedata, input readdata);
  modport slave  (input cs, write, read, byte_en, addr, writedata, output readdata);
endinterface

// File: rtl/maze_wall_lookup.sv
// Maze wall bitmap (160x120 cells, one bit per cell, 600 words of 32 bits)
// written by software over Avalon-MM and looked up per VGA pixel. Each lookup
// returns the pixel's cell plus its four neighbours through a fixed 2-cycle
// pipeline. A hardware sequencer zeroes the whole bitmap on reset or on request.
module maze_wall_lookup (
  input  logic               i_clk,
  input  logic               i_reset,
  maze_wall_lookup_if.slave  avl,
  input  logic [9:0]         i_draw_x,
  input  logic [9:0]         i_draw_y,
  output logic               o_maze_wall,
  output logic               o_wall_up,
  output logic               o_wall_down,
  output logic               o_wall_left,
  output logic               o_wall_right,
  output logic               o_maze_ready,
  output logic               o_clearing
);

  localparam int unsigned NUM_WORDS = 600;
  localparam logic [9:0]  CTRL_ADDR = 10'd600;
  localparam logic [9:0]  LAST_WORD = 10'd599;
  localparam logic [7:0]  LAST_CX   = 8'd159;
  localparam logic [7:0]  LAST_CY   = 8'd119;
  localparam logic [14:0] ROW_CELLS = 15'd160;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  // One lookup result: the pixel's own cell and its four neighbours.
  typedef struct packed {
    logic wall;
    logic up;
    logic down;
    logic left;
    logic right;
  } look_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [9:0]  r_count;
  logic [9:0]  w_count_next;
  logic        r_maze_ready;
  logic [31:0] r_readdata;
  logic [31:0] r_mem [NUM_WORDS];

  look_t       w_look;
  look_t       r_s1_look;
  look_t       r_s2_look;
  look_t       r_out_look;
  logic        r_s1_valid;
  logic        r_s2_valid;

  logic        w_wr;
  logic        w_rd;
  logic        w_maze_addr;
  logic        w_ctrl_wr;
  logic        w_clear_req;
  logic        w_ready_req;
  logic        w_clearing;
  logic        w_clear_we;
  logic        w_maze_we;

  logic        w_off;
  logic [7:0]  w_cx;
  logic [7:0]  w_cy;
  logic [14:0] w_idx;
  logic [14:0] w_idx_up;
  logic [14:0] w_idx_down;
  logic [14:0] w_idx_left;
  logic [14:0] w_idx_right;

  // Bus decode. A control write only counts when byte lane 0 is enabled, and
  // a clear request outranks a maze_ready request in the same write.
  assign w_wr        = avl.cs && avl.write;
  assign w_rd        = avl.cs && avl.read;
  assign w_maze_addr = (avl.addr < CTRL_ADDR);
  assign w_ctrl_wr   = w_wr && (avl.addr == CTRL_ADDR) && avl.byte_en[0];
  assign w_clear_req = w_ctrl_wr && avl.writedata[1];
  assign w_ready_req = w_ctrl_wr && avl.writedata[0] && !avl.writedata[1];

  // Clear sequencer state register; reset parks it in CLEAR at word 0.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from pre-edge values; this is also what makes a lookup
  // issued alongside a write see the word as it was before that write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_CLEAR;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // Clear sequencer next state: walk words 0..599, restart on a new request.
  // NOTE: both targets get a default first so no path through the case can
  // leave them unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      ST_IDLE: begin
        if (w_clear_req) begin
          w_state_next = ST_CLEAR;
          w_count_next = '0;
        end
      end
      ST_CLEAR: begin
        if (w_clear_req) begin
          w_count_next = '0;
        end else if (r_count == LAST_WORD) begin
          w_state_next = ST_IDLE;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + 10'd1;
        end
      end
      default: begin
        w_state_next = ST_CLEAR;
        w_count_next = '0;
      end
    endcase
  end

  // Clear sequencer outputs: the clearing flag and the two bitmap write enables.
  always_comb begin
    w_clearing = (r_state == ST_CLEAR);
    w_clear_we = w_clearing && !i_reset;
    w_maze_we  = w_wr && w_maze_addr && !w_clearing && !i_reset;
  end

  assign o_clearing = w_clearing;

  // Bitmap storage: the sequencer zeroes one word per cycle, otherwise
  // software writes merge the enabled bytes into the addressed word.
  // NOTE: the array deliberately has no reset branch; its contents are wiped
  // by the clear sequencer, which reset always starts.
  always_ff @(posedge i_clk) begin
    if (w_clear_we) begin
      r_mem[r_count] <= '0;
    end else if (w_maze_we) begin
      for (int b = 0; b < 4; b++) begin
        if (avl.byte_en[b]) r_mem[avl.addr][8*b +: 8] <= avl.writedata[8*b +: 8];
      end
    end
  end

  // maze_ready: set by software, dropped by any maze edit or by a clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_maze_ready <= 1'b0;
    end else if (w_clear_req || w_clearing || w_maze_we) begin
      r_maze_ready <= 1'b0;
    end else if (w_ready_req) begin
      r_maze_ready <= 1'b1;
    end
  end

  assign o_maze_ready = r_maze_ready;

  // Avalon read data, registered one cycle after the strobe and held otherwise.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      if (w_maze_addr)                 r_readdata <= r_mem[avl.addr];
      else if (avl.addr == CTRL_ADDR)  r_readdata <= {30'b0, w_clearing, r_maze_ready};
      else                             r_readdata <= '0;
    end
  end

  assign avl.readdata = r_readdata;

  // Cell lookup for the current pixel. Cell rows are exactly 5 words, so the
  // vertical neighbours are +/-160 cells and horizontal ones +/-1 cell; plain
  // index arithmetic carries across word boundaries. Off-grid neighbours read
  // as wall; off-screen pixels return nothing.
  always_comb begin
    w_off       = (i_draw_x >= 10'd640) || (i_draw_y >= 10'd480);
    w_cx        = w_off ? 8'd0 : i_draw_x[9:2];
    w_cy        = w_off ? 8'd0 : i_draw_y[9:2];
    w_idx       = 15'(w_cx) + 15'(w_cy) * ROW_CELLS;
    w_idx_up    = (w_cy == 8'd0)    ? w_idx : w_idx - ROW_CELLS;
    w_idx_down  = (w_cy == LAST_CY) ? w_idx : w_idx + ROW_CELLS;
    w_idx_left  = (w_cx == 8'd0)    ? w_idx : w_idx - 15'd1;
    w_idx_right = (w_cx == LAST_CX) ? w_idx : w_idx + 15'd1;

    w_look.wall  = r_mem[w_idx[14:5]][~w_idx[4:0]];
    w_look.up    = (w_cy == 8'd0)    || r_mem[w_idx_up[14:5]][~w_idx_up[4:0]];
    w_look.down  = (w_cy == LAST_CY) || r_mem[w_idx_down[14:5]][~w_idx_down[4:0]];
    w_look.left  = (w_cx == 8'd0)    || r_mem[w_idx_left[14:5]][~w_idx_left[4:0]];
    w_look.right = (w_cx == LAST_CX) || r_mem[w_idx_right[14:5]][~w_idx_right[4:0]];
    if (w_off) w_look = '0;
  end

  // Lookup pipeline: sample, delay, then register outputs masked while the
  // bitmap is being cleared (using the state that holds after this edge).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_look  <= '0;
      r_s2_look  <= '0;
      r_out_look <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_look  <= w_look;
      r_s1_valid <= 1'b1;
      r_s2_look  <= r_s1_look;
      r_s2_valid <= r_s1_valid;
      r_out_look <= (r_s2_valid && (w_state_next != ST_CLEAR)) ? r_s2_look : '0;
    end
  end

  assign o_maze_wall  = r_out_look.wall;
  assign o_wall_up    = r_out_look.up;
  assign o_wall_down  = r_out_look.down;
  assign o_wall_left  = r_out_look.left;
  assign o_wall_right = r_out_look.right;

endmodule

// File: tb/tb_maze_wall_lookup.sv
// Bench for maze_wall_lookup: directed vector table, clear/restart and
// read-before-write sequences, then randomized traffic against a cell-level model.
`timescale 1ns/1ps
module tb_maze_wall_lookup;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] draw_x, draw_y;
  logic       maze_wall, wall_up, wall_down, wall_left, wall_right;
  logic       maze_ready, clearing;

  maze_wall_lookup_if avl ();

  always #10 clk = ~clk;

  maze_wall_lookup dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .avl          (avl),
    .i_draw_x     (draw_x),
    .i_draw_y     (draw_y),
    .o_maze_wall  (maze_wall),
    .o_wall_up    (wall_up),
    .o_wall_down  (wall_down),
    .o_wall_left  (wall_left),
    .o_wall_right (wall_right),
    .o_maze_ready (maze_ready),
    .o_clearing   (clearing)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mem [600];
  bit          m_clearing;
  int          m_cnt;
  bit          m_ready;
  logic [31:0] m_rd;
  logic [4:0]  m_out;
  logic [4:0]  h_look [2];
  bit          h_valid [2];

  int n_err = 0;
  int n_chk = 0;

  // A cell is a wall if its bitmap bit is set; anything off the grid is a wall.
  function automatic bit cell_wall(int cx, int cy);
    int idx;
    logic [31:0] w;
    if (cx < 0 || cx > 159 || cy < 0 || cy > 119) return 1'b1;
    idx = cx + 160 * cy;
    w = m_mem[idx / 32];
    return w[31 - (idx % 32)];
  endfunction

  // {wall, up, down, left, right} for a pixel.
  function automatic logic [4:0] lookup(int x, int y);
    int cx, cy;
    if (x >= 640 || y >= 480) return 5'b0;
    cx = x / 4;
    cy = y / 4;
    return {cell_wall(cx, cy), cell_wall(cx, cy - 1), cell_wall(cx, cy + 1),
            cell_wall(cx - 1, cy), cell_wall(cx + 1, cy)};
  endfunction

  // Advance the model by one clock edge using the currently driven inputs,
  // then let the DUT take the same edge.
  task automatic step();
    logic [4:0] look_now;
    bit clr_pre, ctrl;
    int a;
    look_now = lookup(int'(draw_x), int'(draw_y));
    clr_pre  = m_clearing;
    a        = int'(avl.addr);
    if (reset) begin
      m_clearing = 1'b1;
      m_cnt      = 0;
      m_ready    = 1'b0;
      m_rd       = '0;
      m_out      = '0;
      h_valid[0] = 1'b0;
      h_valid[1] = 1'b0;
    end else begin
      if (avl.cs && avl.read)
        m_rd = (a < 600) ? m_mem[a] : (a == 600) ? {30'b0, m_clearing, m_ready} : 32'h0;
      ctrl = avl.cs && avl.write && a == 600 && avl.byte_en[0];
      if (clr_pre) begin
        m_mem[m_cnt] = '0;
      end else if (avl.cs && avl.write && a < 600) begin
        for (int b = 0; b < 4; b++)
          if (avl.byte_en[b]) m_mem[a][8*b +: 8] = avl.writedata[8*b +: 8];
        m_ready = 1'b0;
      end
      if (ctrl && avl.writedata[1]) begin
        m_clearing = 1'b1;
        m_cnt      = 0;
        m_ready    = 1'b0;
      end else begin
        if (ctrl && avl.writedata[0] && !clr_pre) m_ready = 1'b1;
        if (clr_pre) begin
          if (m_cnt == 599) begin
            m_clearing = 1'b0;
            m_cnt      = 0;
          end else begin
            m_cnt++;
          end
        end
      end
      m_out      = (h_valid[1] && !m_clearing) ? h_look[1] : 5'b0;
      h_look[1]  = h_look[0];
      h_valid[1] = h_valid[0];
      h_look[0]  = look_now;
      h_valid[0] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] dut_look();
    return {maze_wall, wall_up, wall_down, wall_left, wall_right};
  endfunction

  task automatic compare_all(string tag);
    check({tag, "_rdata"}, avl.readdata, m_rd);
    check({tag, "_look"}, 32'(dut_look()), 32'(m_out));
    check({tag, "_ready"}, 32'(maze_ready), 32'(m_ready));
    check({tag, "_clearing"}, 32'(clearing), 32'(m_clearing));
  endtask

  task automatic bus_idle();
    avl.cs = 1'b0; avl.write = 1'b0; avl.read = 1'b0;
  endtask

  task automatic wr(int addr, logic [31:0] data, logic [3:0] be);
    avl.cs = 1'b1; avl.write = 1'b1; avl.read = 1'b0;
    avl.addr = 10'(addr); avl.writedata = data; avl.byte_en = be;
    step();
    bus_idle();
  endtask

  task automatic rd_check(string name, int addr, logic [31:0] exp);
    avl.cs = 1'b1; avl.read = 1'b1; avl.write = 1'b0; avl.addr = 10'(addr);
    step();
    bus_idle();
    check(name, avl.readdata, exp);
  endtask

  // ---------------- directed lookup table ----------------
  typedef struct {
    string      name;
    int         x;
    int         y;
    logic [4:0] exp;   // {wall, up, down, left, right}
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(int i);
    draw_x = 10'(vecs[i].x);
    draw_y = 10'(vecs[i].y);
    repeat (3) step();
    check(vecs[i].name, 32'(dut_look()), 32'(vecs[i].exp));
  endtask

  int xs [9] = '{0, 3, 124, 127, 128, 131, 636, 639, 640};
  int ys [6] = '{0, 3, 4, 476, 479, 480};

  initial begin
    int cnt;
    vecs[0] = '{"corner_cell",   0,   0,  5'b11010};
    vecs[1] = '{"word_end_right", 124, 0, 5'b11001};
    vecs[2] = '{"word_start_left", 128, 0, 5'b11010};
    vecs[3] = '{"offscreen",     700, 10, 5'b00000};
    vecs[4] = '{"far_corner",    636, 476, 5'b11111};

    foreach (m_mem[i]) m_mem[i] = '0;
    m_clearing = 1'b1; m_cnt = 0; m_ready = 1'b0; m_rd = '0; m_out = '0;
    h_look[0] = '0; h_look[1] = '0; h_valid[0] = 1'b0; h_valid[1] = 1'b0;

    reset = 1'b1;
    bus_idle();
    avl.addr = '0; avl.writedata = '0; avl.byte_en = '0;
    draw_x = '0; draw_y = '0;
    repeat (3) step();
    check("rst_rdata", avl.readdata, 32'h0);
    check("rst_look", 32'(dut_look()), 32'h0);
    check("rst_clearing", 32'(clearing), 32'h1);
    check("rst_ready", 32'(maze_ready), 32'h0);

    // Initial clear: poll the status word for its whole duration.
    reset = 1'b0;
    avl.cs = 1'b1; avl.read = 1'b1; avl.addr = 10'd600;
    cnt = 0;
    while (clearing === 1'b1 && cnt < 700) begin
      cnt++;
      step();
      compare_all("poll");
    end
    check("clear_len", 32'(cnt), 32'd600);
    step();
    check("poll_done", avl.readdata, 32'h0);
    bus_idle();
    rd_check("read_word5", 5, 32'h0);

    // Single wall in the top-left cell.
    wr(0, 32'h8000_0000, 4'hF);
    wr(600, 32'h1, 4'hF);
    run_vec(0);
    rd_check("status_ready", 600, 32'h1);

    // Walls either side of the word 0 / word 1 boundary.
    wr(0, 32'h0000_0001, 4'hF);
    wr(1, 32'h8000_0000, 4'hF);
    run_vec(1);
    run_vec(2);

    // Byte-enable merge and maze_ready drop.
    wr(600, 32'h1, 4'hF);
    check("ready_set", 32'(maze_ready), 32'h1);
    wr(3, 32'hFFFF_FFFF, 4'h2);
    check("ready_drop", 32'(maze_ready), 32'h0);
    rd_check("byte_en_merge", 3, 32'h0000_FF00);
    wr(600, 32'h1, 4'h2);
    check("ctrl_needs_be0", 32'(maze_ready), 32'h0);
    wr(601, 32'hFFFF_FFFF, 4'hF);
    rd_check("unused_addr", 601, 32'h0);

    // Write and lookup of word 10 in the same cycle: old data first.
    avl.cs = 1'b1; avl.write = 1'b1; avl.addr = 10'd10;
    avl.writedata = 32'h8000_0000; avl.byte_en = 4'hF;
    draw_x = 10'd0; draw_y = 10'd8;
    step();
    bus_idle();
    step();
    step();
    check("rbw_old", 32'(maze_wall), 32'h0);
    step();
    check("rbw_new", 32'(maze_wall), 32'h1);

    // Full-wall maze: off-screen and far-corner boundaries.
    for (int i = 0; i < 600; i++) wr(i, 32'hFFFF_FFFF, 4'hF);
    run_vec(3);
    run_vec(4);
    compare_all("full");

    // Clear restarted at cycle 300; writes inside the window are dropped.
    wr(600, 32'h2, 4'hF);
    repeat (299) step();
    wr(600, 32'h2, 4'hF);
    cnt = 0;
    while (clearing === 1'b1 && cnt < 700) begin
      cnt++;
      if (cnt == 100) begin
        avl.cs = 1'b1; avl.write = 1'b1; avl.addr = 10'd7;
        avl.writedata = 32'hFFFF_FFFF; avl.byte_en = 4'hF;
      end else if (cnt == 101) begin
        avl.addr = 10'd600; avl.writedata = 32'h1;
      end else begin
        bus_idle();
      end
      step();
      compare_all("restart");
    end
    bus_idle();
    check("restart_len", 32'(cnt), 32'd600);
    rd_check("dropped_write", 7, 32'h0);
    check("dropped_ready", 32'(maze_ready), 32'h0);

    // Random fill, then randomized traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      wr(i, $urandom, 4'hF);
      compare_all("fill");
    end
    for (int n = 0; n < 2500; n++) begin
      int r;
      bus_idle();
      reset = ($urandom_range(0, 999) == 0);
      r = $urandom_range(0, 99);
      if (r < 30) begin
        avl.cs = 1'b1; avl.write = 1'b1;
        avl.byte_en = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 19) == 0) begin
          avl.addr = 10'(600 + $urandom_range(0, 3));
          avl.writedata = {30'b0, ($urandom_range(0, 39) == 0), 1'b1};
        end else begin
          avl.addr = 10'($urandom_range(0, 599));
          avl.writedata = $urandom;
        end
      end else if (r < 60) begin
        avl.cs = 1'b1; avl.read = 1'b1;
        avl.addr = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 3) == 0) begin
        draw_x = 10'(xs[$urandom_range(0, 8)]);
        draw_y = 10'(ys[$urandom_range(0, 5)]);
      end else begin
        draw_x = 10'($urandom_range(0, 700));
        draw_y = 10'($urandom_range(0, 520));
      end
      step();
      compare_all("rand");
    end
    reset = 1'b0;
    bus_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
